// File: rtl/reflet_reg_bank.sv
// Parametrised register bank with per-bit RW / RO / sticky W1C kinds, write pulses and irq.
// Define REFLET_REG_BANK_READ_CLEAR_EN to make a bus read clear the W1C bits of the register read.
module reflet_reg_bank #(
  parameter int addr_size = 16,
  parameter int base_addr = 0,
  parameter int nb_regs   = 4,
  parameter int word_size = 8,
  parameter logic [nb_regs*word_size-1:0] default_value = '0,
  parameter logic [nb_regs*word_size-1:0] ro_mask       = '0,
  parameter logic [nb_regs*word_size-1:0] w1c_mask      = '0,
  parameter logic [nb_regs*word_size-1:0] irq_mask      = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [addr_size-1:0]           addr,
  input  logic                           write_en,
  input  logic [word_size-1:0]           data_in,
  output logic [word_size-1:0]           data_out,
  input  logic [nb_regs*word_size-1:0]   hw_we,
  input  logic [nb_regs*word_size-1:0]   hw_data,
  input  logic [nb_regs*word_size-1:0]   hw_set,
  output logic [nb_regs*word_size-1:0]   data,
  output logic [nb_regs-1:0]             wr_pulse,
  output logic                           irq
);

  localparam int total_bits = nb_regs * word_size;

  logic [nb_regs-1:0]    sel;
  logic [nb_regs-1:0]    bus_wr;
  logic [nb_regs-1:0]    rd_clr;
  logic [total_bits-1:0] data_q;
  logic [total_bits-1:0] data_next;

  always_comb begin
    sel    = '0;
    bus_wr = '0;
    for (int i = 0; i < nb_regs; i++) begin
      sel[i]    = enable && (addr == addr_size'(base_addr + i));
      bus_wr[i] = sel[i] && write_en;
    end
  end

`ifdef REFLET_REG_BANK_READ_CLEAR_EN
  assign rd_clr = sel & ~{nb_regs{write_en}};
`else
  assign rd_clr = '0;
`endif

  always_comb begin
    data_out = '0;
    for (int i = 0; i < nb_regs; i++) begin
      if (sel[i]) begin
        data_out = data_q[i*word_size +: word_size];
      end
    end
  end

  // Set beats clear on W1C bits so no event is lost; hardware beats the bus on RW bits.
  always_comb begin
    data_next = data_q;
    for (int i = 0; i < nb_regs; i++) begin
      for (int b = 0; b < word_size; b++) begin
        if (w1c_mask[i*word_size+b]) begin
          if (hw_set[i*word_size+b]) begin
            data_next[i*word_size+b] = 1'b1;
          end else if ((bus_wr[i] && data_in[b]) || rd_clr[i]) begin
            data_next[i*word_size+b] = 1'b0;
          end
        end else if (hw_we[i*word_size+b]) begin
          data_next[i*word_size+b] = hw_data[i*word_size+b];
        end else if (!ro_mask[i*word_size+b] && bus_wr[i]) begin
          data_next[i*word_size+b] = data_in[b];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= default_value;
      wr_pulse <= '0;
      irq      <= 1'b0;
    end else begin
      data_q   <= data_next;
      wr_pulse <= bus_wr;
      irq      <= |(data_q & irq_mask & w1c_mask);
    end
  end

  assign data = data_q;

endmodule

// File: doc/reflet_reg_bank.md
Name: reflet_reg_bank

Overview:
- Parametrised bank of `nb_regs` configuration/status registers, each `word_size` bits wide, mapped at consecutive bus addresses starting at `base_addr`.
- Successor to the single-byte peripheral register:
  - each bit is one of three kinds: plain read/write, hardware-owned read-only, or sticky write-1-to-clear status;
  - adds per-register write strobes and a registered interrupt output.
- Sits between the system bus and a peripheral core, replacing per-register instances.

Parameters:
- addr_size, 16: width of the system bus address.
- base_addr, 0: bus address of register 0; register i is at base_addr+i.
- nb_regs, 4: number of registers (1..64).
- word_size, 8: bits per register (1..32).
- default_value, 0: flattened nb_regs*word_size reset values; register i occupies bits [i*word_size +: word_size].
- ro_mask, 0: flattened per-bit mask; 1 = bit is read-only from the bus.
- w1c_mask, 0: flattened per-bit mask; 1 = bit is sticky status, cleared by a bus write of 1.
- irq_mask, 0: flattened per-bit mask of W1C bits that contribute to irq.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- enable  in  1  peripheral select from the bus decoder
- addr  in  addr_size  system bus address
- write_en  in  1  bus write strobe
- data_in  in  word_size  bus write data
- data_out  out  word_size  bus read data; 0 when not addressed
- hw_we  in  nb_regs*word_size  per-bit hardware write enable (RW and RO bits)
- hw_data  in  nb_regs*word_size  per-bit hardware write value
- hw_set  in  nb_regs*word_size  per-bit set pulse for W1C bits
- data  out  nb_regs*word_size  current register contents to the peripheral
- wr_pulse  out  nb_regs  one-cycle pulse per register, high the cycle after a bus write to it
- irq  out  1  registered OR of pending W1C bits under irq_mask

Behaviour:
- Reset:
  - asynchronous and active-low; while reset==0, data=default_value, wr_pulse=0, irq=0, independent of clk;
  - release is sampled at the next posedge clk.
- Address decode: sel_i = enable && addr==base_addr+i; bus_wr_i = sel_i && write_en. Addresses outside the range select nothing.
- RW bit (ro=0, w1c=0), per posedge:
  - if hw_we, bit<=hw_data;
  - else if bus_wr_i, bit<=data_in bit;
  - else hold.
  - Hardware wins over a simultaneous bus write.
- RO bit (ro=1, w1c=0):
  - if hw_we, bit<=hw_data; else hold;
  - bus writes have no effect.
- W1C bit (w1c=1; ro ignored):
  - if hw_set, bit<=1;
  - else if bus_wr_i and data_in bit==1, bit<=0;
  - else hold.
  - Set wins over a simultaneous clear, so no event is lost. hw_we/hw_data are ignored for W1C bits.
- Bus write latency: new value is visible on data and data_out one cycle after the write cycle.
- data_out:
  - combinational: the contents of the selected register, or 0 when no register is selected;
  - reads are side-effect free unless the optional feature is enabled.
- wr_pulse[i] <= bus_wr_i, registered; it pulses on every bus write to register i, including writes to RO bits and W1C writes of 0.
- irq <= |(data & irq_mask & w1c_mask), registered; it goes high one cycle after the bit sets.
- Back-to-back writes to the same register on consecutive cycles are each applied, and each produces a wr_pulse.

Optional Feature:
- Macro: REFLET_REG_BANK_READ_CLEAR_EN.
- With the macro: a bus read (sel_i && !write_en) clears all W1C bits of register i at that posedge.
  - data_out during the read cycle shows the pre-clear value.
  - A simultaneous hw_set still wins.
- Without the macro: reads never modify state, and W1C bits clear only by a write of 1.

Test Plan:
- Parameters for all scenarios: nb_regs=4, word_size=8, base_addr=0x100, default_value=0x00_00_5A_00, ro_mask reg2=0xFF, w1c_mask reg3=0x0F, irq_mask reg3=0x01.
- Reset: assert reset=0 mid-cycle -> data reg1 reads 0x5A immediately, irq=0, wr_pulse=0; bus read 0x101 -> data_out 0x5A; read 0x104 -> 0.
- RW write: write 0xC3 to 0x100 -> wr_pulse[0] high for exactly one cycle next cycle; read 0x100 -> 0xC3. Same cycle as hw_we reg0=0xFF with hw_data=0x11 -> final 0x11.
- RO: write 0xFF to 0x102 -> value unchanged (0x00), wr_pulse[2]=1. Apply hw_we=0xFF, hw_data=0xA5 -> read 0xA5.
- W1C/irq:
  - pulse hw_set reg3 bit0 -> bit0=1, irq=1 one cycle later;
  - write 0x01 to 0x103 -> bit0=0, irq falls next cycle;
  - hw_set bit1 together with write 0x02 -> bit1 stays 1;
  - upper nibble (RW) writable.
- Read-clear (macro defined): set reg3=0x03, read 0x103 -> data_out 0x03, next read 0x00. Macro undefined -> second read still 0x03.
